// File: rtl/varredura_matriz_pkg.sv
// Shared codes and helpers for the LED matrix scan sequencer.
// Level/mode encodings, FSM phases and the image-select bundle.
package varredura_matriz_pkg;

    localparam int unsigned LINHAS = 7;

    localparam logic [1:0] NIVEL_CRIT  = 2'b00;
    localparam logic [1:0] NIVEL_BAIXO = 2'b01;
    localparam logic [1:0] NIVEL_MEDIO = 2'b10;
    localparam logic [1:0] NIVEL_ALTO  = 2'b11;

    localparam logic [1:0] MODO_NENHUM      = 2'b00;
    localparam logic [1:0] MODO_ASPERSAO    = 2'b01;
    localparam logic [1:0] MODO_GOTEJAMENTO = 2'b10;

    typedef enum logic {
        FASE_NIVEL = 1'b0,
        FASE_IRRIG = 1'b1
    } fase_e;

    typedef struct packed {
        logic crit;
        logic baix;
        logic med;
        logic alt;
        logic asp;
        logic got;
    } imagem_t;

    function automatic imagem_t icone_nivel(input logic [1:0] nivel);
        imagem_t img;
        img = '0;
        unique case (nivel)
            NIVEL_CRIT:  img.crit = 1'b1;
            NIVEL_BAIXO: img.baix = 1'b1;
            NIVEL_MEDIO: img.med  = 1'b1;
            NIVEL_ALTO:  img.alt  = 1'b1;
        endcase
        return img;
    endfunction

    // Mode 11 is invalid and behaves like "no irrigation".
    function automatic logic modo_valido(input logic [1:0] modo);
        return (modo == MODO_ASPERSAO) || (modo == MODO_GOTEJAMENTO);
    endfunction

endpackage

// File: rtl/varredura_matriz_if.sv
// Scan bus between the sequencer and the column demux / status inputs.
interface varredura_matriz_if;
    logic [1:0] nivel;
    logic [1:0] modo;
    logic [2:0] S;
    logic [6:0] Linha;
    logic       Crit_001;
    logic       Baix_010;
    logic       Med_011;
    logic       Alt_100;
    logic       Asp_101;
    logic       Got_110;
    logic       fim_quadro;

    modport master (
        input  nivel, modo,
        output S, Linha, Crit_001, Baix_010, Med_011, Alt_100, Asp_101, Got_110, fim_quadro
    );

    modport slave (
        output nivel, modo,
        input  S, Linha, Crit_001, Baix_010, Med_011, Alt_100, Asp_101, Got_110, fim_quadro
    );
endinterface

// File: rtl/varredura_matriz_divisor_tick.sv
// Prescaler: counts 0..DIV-1 and pulses tick for one cycle at DIV-1.
module divisor_tick #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/varredura_matriz.sv
// Row scan sequencer for the 7x5 status matrix; alternates the level icon
// with the irrigation icon every QUADROS_IMG frames.
module varredura_matriz
    import varredura_matriz_pkg::*;
#(
    parameter int unsigned DIV_LINHA   = 50000,
    parameter int unsigned QUADROS_IMG = 100
) (
    input logic                 clk,
    input logic                 reset,
    varredura_matriz_if.master  bus
);
    localparam int unsigned CntW = (QUADROS_IMG > 1) ? $clog2(QUADROS_IMG) : 1;

    logic            tick;
    logic            fronteira;
    logic            modo_ok;
    logic            limite;
    logic [2:0]      s_q, s_d;
    fase_e           fase_q, fase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    imagem_t         img_q, img_d;
    logic            fim_q, fim_d;

    divisor_tick #(
        .DIV (DIV_LINHA)
    ) u_divisor_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign fronteira = tick && (s_q == 3'(LINHAS));
    assign limite    = (cnt_q == CntW'(QUADROS_IMG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q    <= 3'(LINHAS);
            fase_q <= FASE_NIVEL;
            cnt_q  <= '0;
            img_q  <= '0;
            fim_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            fase_q <= fase_d;
            cnt_q  <= cnt_d;
            img_q  <= img_d;
            fim_q  <= fim_d;
        end
    end

    // Inputs are only looked at on the 7->1 wrap, so icons never change mid-frame.
    always_comb begin
        s_d     = s_q;
        fase_d  = fase_q;
        cnt_d   = cnt_q;
        img_d   = img_q;
        fim_d   = fronteira;
        modo_ok = modo_valido(bus.modo);

        if (tick) begin
            s_d = fronteira ? 3'd1 : s_q + 3'd1;
        end

        if (fronteira) begin
            unique case (fase_q)
                FASE_NIVEL: begin
                    img_d = icone_nivel(bus.nivel);
                    if (limite) begin
                        cnt_d = '0;
                        if (modo_ok) begin
                            fase_d = FASE_IRRIG;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FASE_IRRIG: begin
                    if (!modo_ok) begin
                        // Mode dropped: fall back to the level icon right away.
                        fase_d = FASE_NIVEL;
                        cnt_d  = '0;
                        img_d  = icone_nivel(bus.nivel);
                    end else begin
                        img_d     = '0;
                        img_d.asp = (bus.modo == MODO_ASPERSAO);
                        img_d.got = (bus.modo == MODO_GOTEJAMENTO);
                        if (limite) begin
                            cnt_d  = '0;
                            fase_d = FASE_NIVEL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.S          = s_q;
        bus.Linha      = ~(7'd1 << (s_q - 3'd1));
        bus.Crit_001   = img_q.crit;
        bus.Baix_010   = img_q.baix;
        bus.Med_011    = img_q.med;
        bus.Alt_100    = img_q.alt;
        bus.Asp_101    = img_q.asp;
        bus.Got_110    = img_q.got;
        bus.fim_quadro = fim_q;
    end
endmodule
